// File: rtl/rv_regfile_pkg.sv
// ---------------------------------------------------------------------------
// rv_regfile_pkg
// Shared types and default sizes for the register-file port controller.
//   XLEN             : data width
//   REG_AW           : register address width
//   WB_DEPTH_DEFAULT : default writeback buffer depth
//   port_mode_e      : what the single register-file port does this cycle
//   wb_entry_t       : one buffered writeback (destination + value)
// ---------------------------------------------------------------------------
package rv_regfile_pkg;

    localparam int XLEN             = 32;
    localparam int REG_AW           = 5;
    localparam int WB_DEPTH_DEFAULT = 2;

    typedef enum logic [1:0] {
        PORT_IDLE,
        PORT_READ,
        PORT_WRITE
    } port_mode_e;

    typedef struct packed {
        logic [REG_AW-1:0] rd;
        logic [XLEN-1:0]   data;
    } wb_entry_t;

endpackage

// File: rtl/rf_wb_fifo.sv
// ---------------------------------------------------------------------------
// rf_wb_fifo
// Writeback buffer. Entry 0 is always the oldest (head), so the FIFO shifts
// down on pop. Two combinational lookup ports return whether an address is
// pending and, if so, the value of the youngest matching entry.
//   clk, reset          : clock, asynchronous active-high reset
//   push, push_entry    : append an entry (caller guarantees room)
//   pop                 : drop the head (caller guarantees non-empty)
//   count, head         : occupancy and oldest entry
//   lkN_addr/hit/data   : forwarding lookups
// ---------------------------------------------------------------------------
module rf_wb_fifo
    import rv_regfile_pkg::*;
#(
    parameter  int DEPTH = WB_DEPTH_DEFAULT,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  wb_entry_t         push_entry,
    input  logic              pop,
    output logic [CNT_W-1:0]  count,
    output wb_entry_t         head,
    input  logic [REG_AW-1:0] lk1_addr,
    output logic              lk1_hit,
    output logic [XLEN-1:0]   lk1_data,
    input  logic [REG_AW-1:0] lk2_addr,
    output logic              lk2_hit,
    output logic [XLEN-1:0]   lk2_data
);

    wb_entry_t        entries [DEPTH];
    logic [CNT_W-1:0] wr_idx;

    // A push that coincides with a pop lands one slot lower, because the
    // shift frees the slot below the current tail.
    assign wr_idx = count - CNT_W'(pop);
    assign head   = entries[0];

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else begin
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // NOTE: the entry storage has no reset; count alone defines which slots
    // are meaningful, so clearing the data would only add reset fan-out.
    always_ff @(posedge clk) begin
        if (pop) begin
            for (int i = 0; i < DEPTH - 1; i++) begin
                entries[i] <= entries[i+1];
            end
        end
        for (int i = 0; i < DEPTH; i++) begin
            if (push && wr_idx == CNT_W'(i)) begin
                entries[i] <= push_entry;
            end
        end
    end

    // Higher index is younger, so the last match in the scan wins.
    function automatic logic [XLEN:0] lookup(input logic [REG_AW-1:0] addr);
        logic [XLEN:0] res;
        res = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (CNT_W'(i) < count && entries[i].rd == addr) begin
                res = {1'b1, entries[i].data};
            end
        end
        return res;
    endfunction

    // NOTE: combinational outputs are fully assigned on every path (here by
    // the function's own default) so no latch is inferred.
    always_comb begin
        {lk1_hit, lk1_data} = lookup(lk1_addr);
        {lk2_hit, lk2_data} = lookup(lk2_addr);
    end

endmodule

// File: rtl/regfile_port_ctrl.sv
// ---------------------------------------------------------------------------
// regfile_port_ctrl
// Time-multiplexes decode operand reads and write-stage writebacks onto the
// register file's single A1/A2/A3/WD3/WE3 port. Writebacks wait in a small
// FIFO; reads see them through forwarding so operands are always current.
//   clk, reset                  : clock, asynchronous active-high reset
//   rd_req_valid/ready, rs1/rs2 : operand read request from decode
//   rd_rsp_valid, rd_rsp_data*  : operands, one cycle after acceptance
//   wb_valid/ready, wb_rd/data  : writeback request
//   A1, A2, A3, WD3, WE3        : register-file port
//   RD1, RD2                    : register-file read data (registered)
//   idle                        : buffer empty and no response in flight
// ---------------------------------------------------------------------------
module regfile_port_ctrl
    import rv_regfile_pkg::*;
#(
    parameter int WB_DEPTH = WB_DEPTH_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rd_req_valid,
    output logic              rd_req_ready,
    input  logic [REG_AW-1:0] rs1,
    input  logic [REG_AW-1:0] rs2,
    output logic              rd_rsp_valid,
    output logic [XLEN-1:0]   rd_rsp_data1,
    output logic [XLEN-1:0]   rd_rsp_data2,
    input  logic              wb_valid,
    output logic              wb_ready,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic [XLEN-1:0]   wb_data,
    output logic [REG_AW-1:0] A1,
    output logic [REG_AW-1:0] A2,
    output logic [REG_AW-1:0] A3,
    output logic [XLEN-1:0]   WD3,
    output logic              WE3,
    input  logic [XLEN-1:0]   RD1,
    input  logic [XLEN-1:0]   RD2,
    output logic              idle
);

    localparam int CNT_W = $clog2(WB_DEPTH + 1);

    logic [CNT_W-1:0]  count;
    wb_entry_t         head;
    logic              has_room, rd_fire, wb_fire, push, pop;
    logic              lk1_hit, lk2_hit;
    logic [XLEN-1:0]   lk1_data, lk2_data;
    port_mode_e        mode;

    logic              fwd1_hit_d, fwd2_hit_d;
    logic [XLEN-1:0]   fwd1_data_d, fwd2_data_d;
    logic              fwd1_hit_q, fwd2_hit_q;
    logic [XLEN-1:0]   fwd1_data_q, fwd2_data_q;
    logic [REG_AW-1:0] rs1_q, rs2_q;

    assign has_room     = count < CNT_W'(WB_DEPTH);
    assign rd_req_ready = !reset && has_room;
    assign wb_ready     = !reset && has_room;
    assign rd_fire      = rd_req_valid && rd_req_ready;
    assign wb_fire      = wb_valid && wb_ready;
    // Writes to x0 complete the handshake but are dropped here.
    assign push         = wb_fire && (wb_rd != '0);
    assign pop          = (mode == PORT_WRITE);

    rf_wb_fifo #(.DEPTH(WB_DEPTH)) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .push       (push),
        .push_entry ('{rd: wb_rd, data: wb_data}),
        .pop        (pop),
        .count      (count),
        .head       (head),
        .lk1_addr   (rs1),
        .lk1_hit    (lk1_hit),
        .lk1_data   (lk1_data),
        .lk2_addr   (rs2),
        .lk2_hit    (lk2_hit),
        .lk2_data   (lk2_data)
    );

    // A full buffer blocks reads (ready low), so it always drains first.
    always_comb begin
        mode = PORT_IDLE;
        if (!has_room) begin
            mode = PORT_WRITE;
        end else if (rd_fire) begin
            mode = PORT_READ;
        end else if (count != '0) begin
            mode = PORT_WRITE;
        end
    end

    always_comb begin
        WE3 = 1'b0;
        A1  = '0;
        A2  = '0;
        A3  = '0;
        WD3 = '0;
        case (mode)
            PORT_WRITE: begin
                WE3 = 1'b1;
                A3  = head.rd;
                WD3 = head.data;
            end
            PORT_READ: begin
                A1 = rs1;
                A2 = rs2;
            end
            default: ;
        endcase
    end

    // A writeback accepted alongside the read is younger than anything
    // already buffered, so it overrides the FIFO lookup.
    always_comb begin
        fwd1_hit_d  = lk1_hit;
        fwd1_data_d = lk1_data;
        fwd2_hit_d  = lk2_hit;
        fwd2_data_d = lk2_data;
        if (push && wb_rd == rs1) begin
            fwd1_hit_d  = 1'b1;
            fwd1_data_d = wb_data;
        end
        if (push && wb_rd == rs2) begin
            fwd2_hit_d  = 1'b1;
            fwd2_data_d = wb_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_rsp_valid <= 1'b0;
            rs1_q        <= '0;
            rs2_q        <= '0;
            fwd1_hit_q   <= 1'b0;
            fwd2_hit_q   <= 1'b0;
            fwd1_data_q  <= '0;
            fwd2_data_q  <= '0;
        end else begin
            rd_rsp_valid <= rd_fire;
            if (rd_fire) begin
                rs1_q       <= rs1;
                rs2_q       <= rs2;
                fwd1_hit_q  <= fwd1_hit_d;
                fwd2_hit_q  <= fwd2_hit_d;
                fwd1_data_q <= fwd1_data_d;
                fwd2_data_q <= fwd2_data_d;
            end
        end
    end

    always_comb begin
        rd_rsp_data1 = '0;
        rd_rsp_data2 = '0;
        if (rd_rsp_valid && rs1_q != '0) begin
            rd_rsp_data1 = fwd1_hit_q ? fwd1_data_q : RD1;
        end
        if (rd_rsp_valid && rs2_q != '0) begin
            rd_rsp_data2 = fwd2_hit_q ? fwd2_data_q : RD2;
        end
    end

    assign idle = (count == '0) && !rd_rsp_valid;

endmodule

// File: tb/tb_regfile_port_ctrl.sv
// ---------------------------------------------------------------------------
// tb_regfile_port_ctrl
// Self-checking bench. A behavioural register file sits on the port. The
// reference model keeps the architectural register state (updated the moment
// a writeback is accepted) plus an ordered list of not-yet-written results;
// a read must return the architectural state as of its acceptance cycle.
// ---------------------------------------------------------------------------
module tb_regfile_port_ctrl;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        rd_req_valid, rd_req_ready;
    logic [4:0]  rs1, rs2;
    logic        rd_rsp_valid;
    logic [31:0] rd_rsp_data1, rd_rsp_data2;
    logic        wb_valid, wb_ready;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic [4:0]  A1, A2, A3;
    logic [31:0] WD3;
    logic        WE3;
    logic [31:0] RD1, RD2;
    logic        idle;

    regfile_port_ctrl #(.WB_DEPTH(DEPTH)) dut (
        .clk          (clk),
        .reset        (reset),
        .rd_req_valid (rd_req_valid),
        .rd_req_ready (rd_req_ready),
        .rs1          (rs1),
        .rs2          (rs2),
        .rd_rsp_valid (rd_rsp_valid),
        .rd_rsp_data1 (rd_rsp_data1),
        .rd_rsp_data2 (rd_rsp_data2),
        .wb_valid     (wb_valid),
        .wb_ready     (wb_ready),
        .wb_rd        (wb_rd),
        .wb_data      (wb_data),
        .A1           (A1),
        .A2           (A2),
        .A3           (A3),
        .WD3          (WD3),
        .WE3          (WE3),
        .RD1          (RD1),
        .RD2          (RD2),
        .idle         (idle)
    );

    always #5 clk = ~clk;

    // Behavioural 32x32 register file, reset by the same signal.
    logic [31:0] rf_mem [32];
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) rf_mem[i] <= '0;
            RD1 <= '0;
            RD2 <= '0;
        end else begin
            if (WE3 && A3 != 5'd0) rf_mem[A3] <= WD3;
            RD1 <= rf_mem[A1];
            RD2 <= rf_mem[A2];
        end
    end

    // ---------------- reference model ----------------
    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } pend_t;

    pend_t       pending [$];
    logic [31:0] arch [32];
    logic        exp_valid;
    logic [31:0] exp_d1, exp_d2;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        pending.delete();
        for (int i = 0; i < 32; i++) arch[i] = '0;
        exp_valid = 1'b0;
    endtask

    typedef struct {
        logic        rdy;
        logic        we;
        logic [4:0]  a3;
        logic [31:0] wd3;
        logic        rv;
        logic [31:0] d1;
        logic [31:0] d2;
    } obs_t;

    // One clock cycle: drive, check the port at the negedge against the
    // model, advance the model, then check the response after the edge.
    // Entered and left at posedge + 1.
    task automatic cycle(input logic rv, input logic [4:0] r1, input logic [4:0] r2,
                         input logic wv, input logic [4:0] wrd, input logic [31:0] wd,
                         output obs_t o);
        logic        e_rdy, rfire, wfire, e_we;
        logic [4:0]  e_a3;
        logic [31:0] e_wd3;
        rd_req_valid = rv;
        rs1          = r1;
        rs2          = r2;
        wb_valid     = wv;
        wb_rd        = wrd;
        wb_data      = wd;
        @(negedge clk);
        e_rdy = (pending.size() < DEPTH);
        rfire = rv && e_rdy;
        wfire = wv && e_rdy;
        e_we  = !e_rdy || (!rfire && pending.size() > 0);
        e_a3  = '0;
        e_wd3 = '0;
        if (e_we) begin
            e_a3  = pending[0].rd;
            e_wd3 = pending[0].data;
        end
        o.rdy = rd_req_ready;
        o.we  = WE3;
        o.a3  = A3;
        o.wd3 = WD3;
        check("rd_req_ready", {31'd0, rd_req_ready}, {31'd0, e_rdy});
        check("wb_ready", {31'd0, wb_ready}, {31'd0, e_rdy});
        check("WE3", {31'd0, WE3}, {31'd0, e_we});
        check("A1", {27'd0, A1}, (rfire && !e_we) ? {27'd0, r1} : 32'd0);
        check("A2", {27'd0, A2}, (rfire && !e_we) ? {27'd0, r2} : 32'd0);
        check("A3", {27'd0, A3}, {27'd0, e_a3});
        check("WD3", WD3, e_wd3);
        if (e_we) void'(pending.pop_front());
        if (wfire && wrd != 5'd0) begin
            pending.push_back('{rd: wrd, data: wd});
            arch[wrd] = wd;
        end
        exp_valid = rfire;
        exp_d1    = arch[r1];
        exp_d2    = arch[r2];
        @(posedge clk);
        #1;
        o.rv = rd_rsp_valid;
        o.d1 = rd_rsp_data1;
        o.d2 = rd_rsp_data2;
        check("rd_rsp_valid", {31'd0, rd_rsp_valid}, {31'd0, exp_valid});
        if (exp_valid) begin
            check("rd_rsp_data1", rd_rsp_data1, exp_d1);
            check("rd_rsp_data2", rd_rsp_data2, exp_d2);
        end
        check("idle", {31'd0, idle}, {31'd0, (pending.size() == 0) && !exp_valid});
    endtask

    // ---------------- directed vectors ----------------
    typedef struct {
        logic        rv;
        logic [4:0]  r1, r2;
        logic        wv;
        logic [4:0]  wrd;
        logic [31:0] wd;
        logic        e_rdy, e_we;
        logic [4:0]  e_a3;
        logic [31:0] e_wd3;
        logic        e_rv;
        logic [31:0] e_d1, e_d2;
    } vec_t;

    vec_t tbl [13];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        obs_t o;
        int   guard;

        //           rv r1 r2 wv wrd wd            rdy we a3 wd3           rv d1            d2
        tbl[0]  = '{0, 0, 0, 1, 5, 32'h0000_1234, 1, 0, 0, 32'h0,         0, 32'h0,        32'h0};
        tbl[1]  = '{0, 0, 0, 0, 0, 32'h0,         1, 1, 5, 32'h0000_1234, 0, 32'h0,        32'h0};
        tbl[2]  = '{1, 5, 0, 0, 0, 32'h0,         1, 0, 0, 32'h0,         1, 32'h1234,     32'h0};
        tbl[3]  = '{1, 7, 5, 1, 7, 32'hDEAD_BEEF, 1, 0, 0, 32'h0,         1, 32'hDEADBEEF, 32'h1234};
        tbl[4]  = '{0, 0, 0, 0, 0, 32'h0,         1, 1, 7, 32'hDEAD_BEEF, 0, 32'h0,        32'h0};
        tbl[5]  = '{1, 7, 7, 0, 0, 32'h0,         1, 0, 0, 32'h0,         1, 32'hDEADBEEF, 32'hDEADBEEF};
        tbl[6]  = '{1, 0, 0, 1, 3, 32'h1,         1, 0, 0, 32'h0,         1, 32'h0,        32'h0};
        tbl[7]  = '{1, 3, 0, 1, 3, 32'h2,         1, 0, 0, 32'h0,         1, 32'h2,        32'h0};
        tbl[8]  = '{1, 3, 3, 0, 0, 32'h0,         0, 1, 3, 32'h1,         0, 32'h0,        32'h0};
        tbl[9]  = '{1, 3, 3, 0, 0, 32'h0,         1, 0, 0, 32'h0,         1, 32'h2,        32'h2};
        tbl[10] = '{0, 0, 0, 0, 0, 32'h0,         1, 1, 3, 32'h2,         0, 32'h0,        32'h0};
        tbl[11] = '{1, 0, 3, 1, 0, 32'h0000_FFFF, 1, 0, 0, 32'h0,         1, 32'h0,        32'h2};
        tbl[12] = '{0, 0, 0, 0, 0, 32'h0,         1, 0, 0, 32'h0,         0, 32'h0,        32'h0};

        rd_req_valid = 1'b0;
        rs1          = '0;
        rs2          = '0;
        wb_valid     = 1'b0;
        wb_rd        = '0;
        wb_data      = '0;
        reset        = 1'b0;
        model_clear();

        // Reset asserted mid-cycle: outputs must clear without a clock edge.
        #2 reset = 1'b1;
        #1;
        check("rst_rsp_valid", {31'd0, rd_rsp_valid}, 32'd0);
        check("rst_data1", rd_rsp_data1, 32'd0);
        check("rst_data2", rd_rsp_data2, 32'd0);
        check("rst_WE3", {31'd0, WE3}, 32'd0);
        check("rst_addr", {17'd0, A1, A2, A3}, 32'd0);
        check("rst_WD3", WD3, 32'd0);
        check("rst_ready", {30'd0, rd_req_ready, wb_ready}, 32'd0);
        check("rst_idle", {31'd0, idle}, 32'd1);
        repeat (2) begin
            @(posedge clk);
            #1;
            check("rst_hold_WE3", {31'd0, WE3}, 32'd0);
        end
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("post_rst_ready", {31'd0, rd_req_ready}, 32'd1);
        check("post_rst_idle", {31'd0, idle}, 32'd1);

        // Directed table: preload, plain read, same-cycle forward,
        // youngest-wins with full-buffer stall, x0 writeback.
        for (int i = 0; i < 13; i++) begin
            cycle(tbl[i].rv, tbl[i].r1, tbl[i].r2, tbl[i].wv, tbl[i].wrd, tbl[i].wd, o);
            check($sformatf("t%0d_rdy", i), {31'd0, o.rdy}, {31'd0, tbl[i].e_rdy});
            check($sformatf("t%0d_we3", i), {31'd0, o.we}, {31'd0, tbl[i].e_we});
            check($sformatf("t%0d_a3", i), {27'd0, o.a3}, {27'd0, tbl[i].e_a3});
            check($sformatf("t%0d_wd3", i), o.wd3, tbl[i].e_wd3);
            check($sformatf("t%0d_rv", i), {31'd0, o.rv}, {31'd0, tbl[i].e_rv});
            if (tbl[i].e_rv) begin
                check($sformatf("t%0d_d1", i), o.d1, tbl[i].e_d1);
                check($sformatf("t%0d_d2", i), o.d2, tbl[i].e_d2);
            end
        end

        // Reset mid-flight: fill the buffer behind two reads, then reset
        // while the second read's response is pending and a write is due.
        cycle(1, 1, 2, 1, 8, 32'h77, o);
        cycle(1, 1, 2, 1, 9, 32'hAA, o);
        rd_req_valid = 1'b1;
        rs1          = 5'd9;
        rs2          = 5'd8;
        wb_valid     = 1'b1;
        wb_rd        = 5'd10;
        wb_data      = 32'hBB;
        @(negedge clk);
        check("mid_full_WE3", {31'd0, WE3}, 32'd1);
        check("mid_full_ready", {31'd0, rd_req_ready}, 32'd0);
        reset = 1'b1;
        #1;
        check("mid_rst_WE3", {31'd0, WE3}, 32'd0);
        check("mid_rst_rsp_valid", {31'd0, rd_rsp_valid}, 32'd0);
        check("mid_rst_A3", {27'd0, A3}, 32'd0);
        check("mid_rst_idle", {31'd0, idle}, 32'd1);
        model_clear();
        repeat (2) begin
            @(posedge clk);
            #1;
            check("mid_rst_hold_WE3", {31'd0, WE3}, 32'd0);
            check("mid_rst_hold_rsp", {31'd0, rd_rsp_valid}, 32'd0);
        end
        @(negedge clk);
        reset        = 1'b0;
        rd_req_valid = 1'b0;
        wb_valid     = 1'b0;
        @(posedge clk);
        #1;
        check("mid_post_idle", {31'd0, idle}, 32'd1);
        check("mid_post_ready", {31'd0, wb_ready}, 32'd1);
        cycle(1, 9, 8, 0, 0, 32'h0, o);
        check("mid_post_d1", o.d1, 32'd0);
        check("mid_post_d2", o.d2, 32'd0);

        // Randomized traffic on a small register window to force hits,
        // duplicate destinations, x0 writes and full-buffer stalls.
        for (int n = 0; n < 400; n++) begin
            cycle(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                  1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom, o);
        end

        // Drain, then every result must have reached the register file.
        guard = 0;
        while (pending.size() > 0 && guard < 8) begin
            cycle(0, 0, 0, 0, 0, 32'h0, o);
            guard++;
        end
        check("drain_empty", pending.size(), 32'd0);
        for (int i = 0; i < 32; i++) begin
            check($sformatf("rf_x%0d", i), rf_mem[i], arch[i]);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/regfile_port_ctrl.md
# regfile_port_ctrl

Initiator side of the 32×32 register-file port: accepts operand-read requests from decode and writeback requests from the write stage, and time-multiplexes them onto the register file's single A1/A2/A3/WD3/WE3 port. That port either reads (WE3=0, RD1/RD2 registered at the clock edge) or writes (WE3=1) in a given cycle. Pending writebacks sit in a small buffer with read-after-write forwarding, so decode sees architecturally current values.

## Interface
- XLEN, 32, data width
- REG_AW, 5, register address width
- WB_DEPTH, 2, writeback buffer entries (≥1)

- clk  in  1  single clock, all state on rising edge
- reset  in  1  asynchronous, active-high
- rd_req_valid  in  1  decode read request
- rd_req_ready  out  1  request accepted when valid&ready
- rs1, rs2  in  REG_AW  source register numbers
- rd_rsp_valid  out  1  one-cycle pulse carrying operands
- rd_rsp_data1, rd_rsp_data2  out  XLEN  operand values
- wb_valid  in  1  writeback request
- wb_ready  out  1  writeback accepted when valid&ready
- wb_rd  in  REG_AW  destination register
- wb_data  in  XLEN  result
- A1, A2, A3  out  REG_AW  register-file addresses
- WD3  out  XLEN  register-file write data
- WE3  out  1  register-file write enable
- RD1, RD2  in  XLEN  register-file read data
- idle  out  1  buffer empty and no response in flight

## Operation
- Port mode is decided combinationally each cycle:
  - **WRITE** if buffer count == WB_DEPTH, or count>0 and no read is accepted.
  - **READ** if a read is accepted.
  - **IDLE** otherwise.
- **WRITE**: WE3=1, A3/WD3 = buffer head. Pop at the edge. A1/A2 = 0.
- **READ**: WE3=0, A1=rs1, A2=rs2. The register file captures at the edge.
- **IDLE**: WE3=0, all addresses 0, WD3=0.
- rd_req_ready = !reset && count < WB_DEPTH. A full buffer forces a write, so reads stall exactly one cycle per full event.
- wb_ready = !reset && count < WB_DEPTH. Push and pop in the same cycle leave count unchanged.
- wb_rd == 0: the write is accepted (handshake completes) but never buffered.
- Buffer is FIFO. Duplicate destinations are allowed, and the youngest entry wins on forward.
- Forwarding is evaluated in the read-issue cycle and registered:
  - Sources searched: buffer entries plus a wb accepted in the same cycle. A same-cycle wb counts as older than the read, i.e. it is visible to the read.
  - The youngest match supplies the data.
  - Register 0 always reads 0.
- Response cycle: rd_rsp_dataN = fwd_hitN ? fwd_dataN : RDN. Forced to 0 when the registered rsN was 0.
- rd_rsp has no backpressure. Decode must consume the pulse.
- idle = (count==0) && !rd_rsp_valid.

## Timing
- Read latency: request accepted in cycle N → rd_rsp_valid in cycle N+1. Back-to-back reads sustain one per cycle.
- Write visibility: a wb accepted in cycle N is forwardable to a read accepted in cycle N or later. It reaches the register file no earlier than cycle N+1.
- Reset (asynchronous, while high and after release):
  - count=0; fwd/rs registers 0.
  - rd_rsp_valid=0; rd_rsp_data1/2=0.
  - WE3=0; A1=A2=A3=0; WD3=0.
  - ready outputs 0 while reset is high; idle=1.
  - First handshake is possible in the first cycle after deassertion.
- Reset mid-operation: buffered writebacks are discarded, and a pending response is squashed (no pulse). The register file is reset by the same signal.
- WE3 is never high during reset, and is never high in a READ cycle.

## Structure
- Package rv_regfile_pkg holds:
  - XLEN, REG_AW, WB_DEPTH defaults.
  - enum port_mode_e {PORT_IDLE, PORT_READ, PORT_WRITE}.
  - wb_entry_t struct {rd, data}.
- Sub-module rf_wb_fifo:
  - Parameterized FIFO of wb_entry_t with count, head output, and two combinational lookup ports.
  - Each lookup port takes an address and returns hit plus youngest-match data.
- The top level holds the mode decision, the forwarding registers and the response mux.

## Test plan
- Reset then idle: reset pulse mid-cycle → all outputs 0 asynchronously; after release, ready=1, idle=1, WE3 never asserted.
- Plain read: regfile preloaded x5=0x1234; read rs1=5, rs2=0 → next cycle rd_rsp_valid=1, data1=0x1234, data2=0.
- Forward same cycle: wb x7=0xDEADBEEF and read rs1=7 in the same cycle → response data1=0xDEADBEEF. A later write cycle shows WE3=1, A3=7.
- Youngest wins / full stall (WB_DEPTH=2): continuous reads; wb x3=1, then x3=2 → buffer full, next cycle WRITE (A3=3, WD3=1), rd_req_ready=0 for exactly that cycle, a subsequent read of x3 returns 2.
- x0 writes: wb x0=0xFFFF → handshake completes, count stays 0, WE3 stays 0, a read of x0 returns 0.
- Reset mid-flight: two buffered writes plus an issued read; assert reset → no rd_rsp pulse, no WE3; after release idle=1 and reads return 0.
